// File: rtl/isqrt_rr_arbiter.sv
// isqrt_rr_arbiter: round-robin sharing of one pipelined isqrt among N_REQ requesters with in-order tag return
module isqrt_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 req_vld,
  input  logic [N_REQ*32-1:0]              req_x,
  output logic [N_REQ-1:0]                 req_rdy,
  output logic [N_REQ-1:0]                 rsp_vld,
  output logic [15:0]                      rsp_y,
  output logic                             isqrt_x_vld,
  output logic [31:0]                      isqrt_x,
  input  logic                             isqrt_y_vld,
  input  logic [15:0]                      isqrt_y,
  output logic [$clog2(TAG_DEPTH+1)-1:0]   inflight,
  output logic                             err
);
  localparam int TW = $clog2(N_REQ);
  localparam int PW = TAG_DEPTH > 1 ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH+1);
  logic [TW-1:0] last, grant, idx;
  logic [TW-1:0] tags [TAG_DEPTH];
  logic [PW-1:0] wp, rp;
  logic full, empty, issue, pop;
  assign full = inflight == CW'(TAG_DEPTH);
  assign empty = inflight == '0;
  assign issue = |req_vld & ~full;
  assign pop = isqrt_y_vld & ~empty;
  assign isqrt_x_vld = issue;
  assign isqrt_x = issue ? req_x[{grant, 5'd0} +: 32] : '0;
  assign req_rdy = issue ? N_REQ'(1) << grant : '0;
  // nearest requester after the last grant wins; scan from farthest so the nearest overrides
  always_comb begin
    grant = last;
    idx = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = TW'((int'(last) + k) % N_REQ);
      if (req_vld[idx]) grant = idx;
    end
  end
  // priority pointer, tag FIFO pointers/occupancy, routed response and sticky underflow error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= TW'(N_REQ-1);
      wp <= '0;
      rp <= '0;
      inflight <= '0;
      rsp_vld <= '0;
      rsp_y <= '0;
      err <= 1'b0;
    end else begin
      if (issue) last <= grant;
      if (issue) wp <= wp == PW'(TAG_DEPTH-1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == PW'(TAG_DEPTH-1) ? '0 : rp + 1'b1;
      inflight <= inflight + CW'(issue) - CW'(pop);
      rsp_vld <= pop ? N_REQ'(1) << tags[rp] : '0;
      if (pop) rsp_y <= isqrt_y;
      err <= err | (isqrt_y_vld & empty);
    end
  end
  // tag storage: issuer index of each in-flight operation
  always_ff @(posedge clk) begin
    if (issue) tags[wp] <= grant;
  end
endmodule

// File: doc/isqrt_rr_arbiter.md
Name: isqrt_rr_arbiter

Overview:
- Shares one pipelined isqrt instance among N_REQ independent requesters, e.g. several formula FSMs that each need repeated square roots.
- Arbitrates round-robin on the request side and issues at most one isqrt operation per cycle.
- Tracks in-flight operations with an in-order tag FIFO and routes each isqrt result back to the requester that issued it.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TAG_DEPTH, 16, tag FIFO depth; must be at least the isqrt latency + 1 to sustain one issue per cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_vld  in  N_REQ  per-requester operand valid.
- req_x  in  N_REQ*32  per-requester operand; slice i is bits [32*i+31:32*i].
- req_rdy  out  N_REQ  per-requester accept; a transfer occurs when req_vld[i] & req_rdy[i].
- rsp_vld  out  N_REQ  per-requester result valid, one-cycle pulse.
- rsp_y  out  16  result value, shared by all requesters and qualified by rsp_vld.
- isqrt_x_vld  out  1  operand valid to the isqrt instance.
- isqrt_x  out  32  operand to the isqrt instance.
- isqrt_y_vld  in  1  result valid from the isqrt instance.
- isqrt_y  in  16  result from the isqrt instance.
- inflight  out  $clog2(TAG_DEPTH+1)  number of operations issued but not yet returned.
- err  out  1  sticky flag: a result arrived with the tag FIFO empty.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rsp_vld=0, rsp_y=0, err=0, inflight=0.
  - Tag FIFO emptied; round-robin pointer set so that requester 0 has top priority.
  - The isqrt instance shares rst_n, so no operation survives reset.
- Arbitration (combinational):
  - grant goes to the first i with req_vld[i]=1, scanning from (last_grant+1) mod N_REQ upward with wrap.
  - req_rdy[i] = (i==grant) & any(req_vld) & ~fifo_full. At most one req_rdy is high per cycle.
  - req_rdy is 0 for all i when no request is pending or the tag FIFO is full.
- Issue, same cycle as the accept:
  - isqrt_x_vld = any(req_vld) & ~fifo_full.
  - isqrt_x = req_x slice of grant when isqrt_x_vld=1; otherwise 0.
  - The grant index is pushed into the tag FIFO.
  - last_grant updates at the next clk edge, only on an issue.
- Requester contract:
  - req_x is held stable while req_vld=1 and req_rdy=0.
  - A requester may hold req_vld high continuously and is then served every N_REQ cycles under full contention.
- Return:
  - The isqrt returns results in issue order.
  - On isqrt_y_vld=1 with the FIFO non-empty, the head tag is popped.
  - Next cycle: rsp_vld[tag]=1, all other rsp_vld bits 0, and rsp_y=isqrt_y.
  - Latency, accept to rsp_vld: isqrt latency + 1 cycle.
- rsp_y holds its last value when rsp_vld=0.
- Simultaneous push and pop in the same cycle:
  - Both happen.
  - inflight is unchanged.
  - fifo_full is evaluated before the pop; a pop does not make room in the same cycle.
- Result arriving with the tag FIFO empty: dropped, no rsp_vld, err set to 1 until reset.
- Tag FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - Tag width is $clog2(N_REQ).
  - inflight = occupancy.
- Single requester active: it is granted every cycle, limited only by fifo_full.

Test Plan:
- Single request, bench isqrt model with latency 4: req_vld[2]=1 with req_x=144 for one accepted cycle. Required: isqrt_x=144 in the same cycle, rsp_vld=4'b0100 with rsp_y=12 five cycles later, inflight 1 then back to 0.
- Full contention: all four req_vld held high with operands 1, 4, 9, 16. Required:
  - Grants follow 0,1,2,3,0,... one per cycle.
  - Responses arrive in the same order with values 1, 2, 3, 4.
  - No requester starves.
- Back-pressure: TAG_DEPTH=4, isqrt model latency 8, requester 0 streaming. Required:
  - req_rdy drops after 4 issues; inflight=4.
  - Issuing resumes one cycle after the first pop.
  - No result is lost or misrouted.
- Wrap-around: issue 40 operations from random requesters through TAG_DEPTH=16. Required: every response is routed to its issuer and matches floor(sqrt(x)), with x=0 giving 0 and x=32'hFFFF_FFFF giving 16'hFFFF.
- Spurious result: isqrt_y_vld pulsed with inflight=0. Required: err=1 and stays 1, rsp_vld stays 0, err clears only on reset.
- Reset mid-operation: rst_n asserted with inflight=3. Required: outputs go to their reset values immediately, with no rsp_vld after release; a new request then proceeds normally starting from requester 0 priority.
